// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA 640x480@60 timing generator running on the system clock.
// The pixel rate comes from a clock-enable divider (pix_en), so there is one clock domain.
// Optional feature macro: VGA_SYNC_ALIGN_EN adds one clk register stage on hsync/vsync
// so the sync edges line up with a one-clk registered RGB output stage.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       vidon,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam int unsigned DIV_W = 4;
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);

    // Boundaries compared one bit wider so a full 1024 count cannot alias to 0
    localparam logic [CMP_W-1:0] H_VIS_X = CMP_W'(H_VIS);
    localparam logic [CMP_W-1:0] H_SS_X  = CMP_W'(H_VIS + H_FP);
    localparam logic [CMP_W-1:0] H_SE_X  = CMP_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] V_VIS_X = CMP_W'(V_VIS);
    localparam logic [CMP_W-1:0] V_SS_X  = CMP_W'(V_VIS + V_FP);
    localparam logic [CMP_W-1:0] V_SE_X  = CMP_W'(V_VIS + V_FP + V_SYNC);

    // Reject parameter sets whose totals or divider do not fit the counters
    if (H_TOT > (1 << CNT_W) || V_TOT > (1 << CNT_W)) begin : g_bad_total
        $error("vga_timing_gen: H_TOT/V_TOT must fit in 10 bits");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;
    logic [CNT_W-1:0] w_hc_nxt;
    logic [CNT_W-1:0] w_vc_nxt;
    logic             w_frame_wrap;
    logic             w_vidon_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             r_pix_en;
    logic             r_vidon;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    // Next divider and counter values; counters step only on a pix_en cycle
    always_comb begin
        w_div_nxt    = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        w_hc_nxt     = r_hc;
        w_vc_nxt     = r_vc;
        w_frame_wrap = 1'b0;
        if (r_pix_en) begin
            if (r_hc == H_LAST) begin
                w_hc_nxt = '0;
                if (r_vc == V_LAST) begin
                    w_vc_nxt     = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_vc_nxt = r_vc + CNT_W'(1);
                end
            end else begin
                w_hc_nxt = r_hc + CNT_W'(1);
            end
        end
    end

    // Decode visible area and sync windows from the next counts so outputs match hc/vc
    always_comb begin
        w_vidon_nxt = ({1'b0, w_hc_nxt} < H_VIS_X) && ({1'b0, w_vc_nxt} < V_VIS_X);
        w_hsync_nxt = !(({1'b0, w_hc_nxt} >= H_SS_X) && ({1'b0, w_hc_nxt} < H_SE_X));
        w_vsync_nxt = !(({1'b0, w_vc_nxt} >= V_SS_X) && ({1'b0, w_vc_nxt} < V_SE_X));
    end

    // Timing state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_pix_en      <= 1'b0;
            r_vidon       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_pix_en      <= (w_div_nxt == DIV_LAST);
            r_vidon       <= w_vidon_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic r_hsync_d;
    logic r_vsync_d;

    // Extra sync stage matching the one-clk RGB register downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync_d <= 1'b1;
            r_vsync_d <= 1'b1;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign pix_en      = r_pix_en;
    assign hc          = r_hc;
    assign vc          = r_vc;
    assign vidon       = r_vidon;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Three instances share clk/rst_n: default 640x480 (CLK_DIV=2), a tiny frame with CLK_DIV=3,
// and the same tiny frame with CLK_DIV=1, so whole frames fit in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       vidon;
        logic       hsync;
        logic       vsync;
        logic       fs;
    } obs_t;

    localparam int NSIG = 7;
    localparam int NDUT = 3;
`ifdef VGA_SYNC_ALIGN_EN
    localparam int SYNC_DLY = 1;
`else
    localparam int SYNC_DLY = 0;
`endif

    localparam int CD  [NDUT] = '{2, 3, 1};
    localparam int HV  [NDUT] = '{640, 8, 8};
    localparam int HFP [NDUT] = '{16, 2, 2};
    localparam int HS  [NDUT] = '{96, 3, 3};
    localparam int HBP [NDUT] = '{48, 2, 2};
    localparam int VV  [NDUT] = '{480, 4, 4};
    localparam int VFP [NDUT] = '{10, 1, 1};
    localparam int VS  [NDUT] = '{2, 2, 2};
    localparam int VBP [NDUT] = '{33, 1, 1};

    logic clk = 1'b0;
    logic rst_n;

    logic       d_pix_en, s_pix_en, o_pix_en;
    logic [9:0] d_hc, s_hc, o_hc;
    logic [9:0] d_vc, s_vc, o_vc;
    logic       d_vidon, s_vidon, o_vidon;
    logic       d_hsync, s_hsync, o_hsync;
    logic       d_vsync, s_vsync, o_vsync;
    logic       d_fs, s_fs, o_fs;

    obs_t act [NDUT];

    int n_tests;
    int n_fail;
    int err [NDUT][NSIG];

    int t_vid_line1, t_hs_line1, t_hs_first_hc, t_hs_fall_k, t_vid_fall_k;
    int t_wraps, t_wrap_bad, t_s_vid_blank, t_s_fs_cnt, t_s_fs_bad;
    int t_o_fs_cnt, t_o_fs_bad, t_s_vs_low, t_s_vs_midline, t_o_pix_low;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_d (
        .clk(clk), .rst_n(rst_n), .pix_en(d_pix_en), .hc(d_hc), .vc(d_vc),
        .vidon(d_vidon), .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en), .hc(s_hc), .vc(s_vc),
        .vidon(s_vidon), .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_dut_o (
        .clk(clk), .rst_n(rst_n), .pix_en(o_pix_en), .hc(o_hc), .vc(o_vc),
        .vidon(o_vidon), .hsync(o_hsync), .vsync(o_vsync), .frame_start(o_fs)
    );

    assign act[0] = {d_pix_en, d_hc, d_vc, d_vidon, d_hsync, d_vsync, d_fs};
    assign act[1] = {s_pix_en, s_hc, s_vc, s_vidon, s_hsync, s_vsync, s_fs};
    assign act[2] = {o_pix_en, o_hc, o_vc, o_vidon, o_hsync, o_vsync, o_fs};

    // Pixel periods completed after k clks since reset release
    function automatic int pix_count(int d, int k);
        if (k < 1) return 0;
        return (d == 1) ? k - 1 : k / d;
    endfunction

    // Closed-form expected outputs at the k-th sample after reset release
    function automatic obs_t model(int i, int k);
        obs_t m;
        int ht, vt, p, h, v, j, pj, hj, vj;
        ht = HV[i] + HFP[i] + HS[i] + HBP[i];
        vt = VV[i] + VFP[i] + VS[i] + VBP[i];
        p  = pix_count(CD[i], k);
        h  = p % ht;
        v  = (p / ht) % vt;
        j  = (k > SYNC_DLY) ? k - SYNC_DLY : 0;
        pj = pix_count(CD[i], j);
        hj = pj % ht;
        vj = (pj / ht) % vt;
        m.pix_en = (k >= 1) && ((k % CD[i]) == CD[i] - 1);
        m.hc     = 10'(h);
        m.vc     = 10'(v);
        m.vidon  = (k >= 1) && (h < HV[i]) && (v < VV[i]);
        m.hsync  = !((hj >= HV[i] + HFP[i]) && (hj < HV[i] + HFP[i] + HS[i]));
        m.vsync  = !((vj >= VV[i] + VFP[i]) && (vj < VV[i] + VFP[i] + VS[i]));
        m.fs     = (k >= 2) && ((k % CD[i]) == 0) && ((p % (ht * vt)) == 0);
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(int k);
        obs_t m;
        for (int i = 0; i < NDUT; i++) begin
            m = model(i, k);
            if (act[i].pix_en !== m.pix_en) err[i][0]++;
            if (act[i].hc     !== m.hc)     err[i][1]++;
            if (act[i].vc     !== m.vc)     err[i][2]++;
            if (act[i].vidon  !== m.vidon)  err[i][3]++;
            if (act[i].hsync  !== m.hsync)  err[i][4]++;
            if (act[i].vsync  !== m.vsync)  err[i][5]++;
            if (act[i].fs     !== m.fs)     err[i][6]++;
        end
    endtask

    task automatic chk_errs(string phase);
        string names [NSIG];
        names = '{"pix_en", "hc", "vc", "vidon", "hsync", "vsync", "frame_start"};
        for (int i = 0; i < NDUT; i++) begin
            for (int s = 0; s < NSIG; s++) begin
                chk($sformatf("%s dut%0d %s mismatch cycles", phase, i, names[s]), 32'(err[i][s]), 32'd0);
                err[i][s] = 0;
            end
        end
    endtask

    task automatic chk_reset(string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("%s dut%0d pix_en", tag, i),      32'(act[i].pix_en), 32'd0);
            chk($sformatf("%s dut%0d hc", tag, i),          32'(act[i].hc),     32'd0);
            chk($sformatf("%s dut%0d vc", tag, i),          32'(act[i].vc),     32'd0);
            chk($sformatf("%s dut%0d vidon", tag, i),       32'(act[i].vidon),  32'd0);
            chk($sformatf("%s dut%0d hsync", tag, i),       32'(act[i].hsync),  32'd1);
            chk($sformatf("%s dut%0d vsync", tag, i),       32'(act[i].vsync),  32'd1);
            chk($sformatf("%s dut%0d frame_start", tag, i), 32'(act[i].fs),     32'd0);
        end
    endtask

    // Run n_clk clocks from reset release, scoring every sample and gathering event tallies
    task automatic run_phase(int n_clk);
        obs_t pd, ps, po;
        int s_fs_last, o_fs_last;
        t_vid_line1 = 0; t_hs_line1 = 0; t_hs_first_hc = -1; t_hs_fall_k = -1;
        t_vid_fall_k = -1; t_wraps = 0; t_wrap_bad = 0; t_s_vid_blank = 0;
        t_s_fs_cnt = 0; t_s_fs_bad = 0; t_o_fs_cnt = 0; t_o_fs_bad = 0;
        t_s_vs_low = 0; t_s_vs_midline = 0; t_o_pix_low = 0;
        s_fs_last = -1; o_fs_last = -1;
        compare_all(0);
        pd = act[0]; ps = act[1]; po = act[2];
        for (int k = 1; k <= n_clk; k++) begin
            @(negedge clk);
            compare_all(k);
            if (act[0].pix_en === 1'b1 && act[0].vc == 10'd1) begin
                if (act[0].vidon === 1'b1) t_vid_line1++;
                if (act[0].hsync === 1'b0) begin
                    if (t_hs_line1 == 0) t_hs_first_hc = int'(act[0].hc);
                    t_hs_line1++;
                end
            end
            if (pd.hsync === 1'b1 && act[0].hsync === 1'b0 && t_hs_fall_k < 0) t_hs_fall_k = k;
            if (pd.vidon === 1'b1 && act[0].vidon === 1'b0 && t_vid_fall_k < 0) t_vid_fall_k = k;
            if (pd.hc == 10'd799 && act[0].hc != 10'd799) begin
                t_wraps++;
                if (act[0].hc != 10'd0 || act[0].vc != pd.vc + 10'd1) t_wrap_bad++;
            end
            if (act[1].vidon === 1'b1 && act[1].vc >= 10'd4) t_s_vid_blank++;
            if (act[1].pix_en === 1'b1 && act[1].vsync === 1'b0) t_s_vs_low++;
            if (act[1].vsync !== ps.vsync && act[1].hc != 10'd0) t_s_vs_midline++;
            if (act[1].fs === 1'b1) begin
                if (s_fs_last >= 0 && k - s_fs_last != 360) t_s_fs_bad++;
                s_fs_last = k;
                t_s_fs_cnt++;
            end
            if (act[2].fs === 1'b1) begin
                if (o_fs_last >= 0 && k - o_fs_last != 120) t_o_fs_bad++;
                o_fs_last = k;
                t_o_fs_cnt++;
            end
            if (act[2].pix_en !== 1'b1) t_o_pix_low++;
            pd = act[0]; ps = act[1]; po = act[2];
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < NDUT; i++)
            for (int s = 0; s < NSIG; s++)
                err[i][s] = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");

        // Three default lines (p = 0..2700) and fifteen small frames
        rst_n = 1'b1;
        run_phase(5400);
        chk_errs("run");
        chk("line1 vidon pix periods", 32'(t_vid_line1), 32'd640);
        chk("line1 hsync low pix periods", 32'(t_hs_line1), 32'd96);
        chk("line1 hsync first low hc", 32'(t_hs_first_hc), 32'd656);
        chk("hsync fall clk", 32'(t_hs_fall_k), 32'(1312 + SYNC_DLY));
        chk("vidon fall clk", 32'(t_vid_fall_k), 32'd1280);
        chk("hc 799 wraps seen", 32'(t_wraps), 32'd3);
        chk("wrap hc0/vc+1 bad", 32'(t_wrap_bad), 32'd0);
        chk("small vidon in vblank", 32'(t_s_vid_blank), 32'd0);
        chk("small vsync low pix periods", 32'(t_s_vs_low), 32'd450);
        chk("small vsync change mid-line", 32'(t_s_vs_midline), 32'd0);
        chk("small frame_start count", 32'(t_s_fs_cnt), 32'd15);
        chk("small frame_start period bad", 32'(t_s_fs_bad), 32'd0);
        chk("div1 frame_start count", 32'(t_o_fs_cnt), 32'd44);
        chk("div1 frame_start period bad", 32'(t_o_fs_bad), 32'd0);
        chk("div1 pix_en low cycles", 32'(t_o_pix_low), 32'd0);
        chk("pre-reset hc", 32'(d_hc), 32'd300);
        chk("pre-reset vc", 32'(d_vc), 32'd3);

        // Asynchronous reset mid-line, checked before the next rising edge
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_phase(2000);
        chk_errs("restart");
        chk("restart hc", 32'(d_hc), 32'd200);
        chk("restart vc", 32'(d_vc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
